// File: rtl/sad_best_match.sv
// sad_best_match: accumulates ROWS row SADs per candidate block and keeps the minimum over NUM_CAND candidates
//   clk       : clock, all state changes on the rising edge
//   rst       : asynchronous active-high reset
//   start     : begins a search when sampled high in IDLE
//   sad_in    : 12-bit row SAD from the upstream stage
//   sad_valid : sad_in is valid
//   sad_ready : high only in ACCUM; a transfer happens when sad_valid and sad_ready are both high
//   best_sad  : minimum block SAD found so far
//   best_idx  : candidate index of best_sad
//   busy      : high whenever the FSM is not in IDLE
//   done      : one-cycle pulse when the search completes
module sad_best_match #(
    parameter int ROWS     = 16,
    parameter int NUM_CAND = 49,
    parameter int CAND_W   = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [11:0]       sad_in,
    input  logic              sad_valid,
    output logic              sad_ready,
    output logic [15:0]       best_sad,
    output logic [CAND_W-1:0] best_idx,
    output logic              busy,
    output logic              done
);
    typedef enum logic [1:0] {IDLE, ACCUM, COMPARE, DONE} state_t;
    localparam logic [4:0]        LAST_ROW  = 5'(ROWS - 1);
    localparam logic [CAND_W-1:0] LAST_CAND = CAND_W'(NUM_CAND - 1);
    state_t            r_state;
    logic [4:0]        r_row;
    logic [CAND_W-1:0] r_cand;
    logic [15:0]       r_acc;
    logic [15:0]       r_best_sad;
    logic [CAND_W-1:0] r_best_idx;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_row      <= '0;
            r_cand     <= '0;
            r_acc      <= '0;
            r_best_sad <= 16'hFFFF;
            r_best_idx <= '0;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_state    <= ACCUM;
                    r_row      <= '0;
                    r_cand     <= '0;
                    r_acc      <= '0;
                    r_best_sad <= 16'hFFFF;
                    r_best_idx <= '0;
                end
                ACCUM: if (sad_valid) begin
                    r_acc   <= r_acc + {4'b0, sad_in};
                    r_row   <= r_row + 5'd1;
                    r_state <= (r_row == LAST_ROW) ? COMPARE : ACCUM;
                end
                COMPARE: begin
                    // strict less-than so a tie keeps the earlier candidate
                    if (r_acc < r_best_sad) begin
                        r_best_sad <= r_acc;
                        r_best_idx <= r_cand;
                    end
                    r_acc   <= '0;
                    r_row   <= '0;
                    r_cand  <= (r_cand == LAST_CAND) ? r_cand : r_cand + 1'b1;
                    r_state <= (r_cand == LAST_CAND) ? DONE : ACCUM;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign sad_ready = (r_state == ACCUM);
    assign busy      = (r_state != IDLE);
    assign done      = (r_state == DONE);
    assign best_sad  = r_best_sad;
    assign best_idx  = r_best_idx;
endmodule

// File: tb/tb_sad_best_match.sv
// tb_sad_best_match: randomized self-checking bench for sad_best_match against a queue-based reference
module tb_sad_best_match;
    logic        clk;
    logic        rst;
    logic        start_a, valid_a, ready_a, busy_a, done_a;
    logic [11:0] sad_in_a;
    logic [15:0] best_sad_a;
    logic [5:0]  best_idx_a;
    logic        start_b, valid_b, ready_b, busy_b, done_b;
    logic [11:0] sad_in_b;
    logic [15:0] best_sad_b;
    logic [1:0]  best_idx_b;
    int n_chk = 0;
    int n_bad = 0;
    int xfer_a = 0, xfer_b = 0, ndone_a = 0, ndone_b = 0;
    int got_sad, got_idx;

    sad_best_match #(.ROWS(16), .NUM_CAND(1), .CAND_W(6)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .sad_in(sad_in_a), .sad_valid(valid_a),
        .sad_ready(ready_a), .best_sad(best_sad_a), .best_idx(best_idx_a), .busy(busy_a), .done(done_a)
    );
    sad_best_match #(.ROWS(2), .NUM_CAND(3), .CAND_W(2)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .sad_in(sad_in_b), .sad_valid(valid_b),
        .sad_ready(ready_b), .best_sad(best_sad_b), .best_idx(best_idx_b), .busy(busy_b), .done(done_b)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (valid_a && ready_a) xfer_a <= xfer_a + 1;
        if (valid_b && ready_b) xfer_b <= xfer_b + 1;
        if (done_a) ndone_a <= ndone_a + 1;
        if (done_b) ndone_b <= ndone_b + 1;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // reference: block sums from consecutive groups of rows, first strict minimum wins
    task automatic ref_best(input int data[$], input int rows, output int bs, output int bi);
        bs = 16'hFFFF;
        bi = 0;
        for (int c = 0; c < data.size() / rows; c++) begin
            int s = 0;
            for (int r = 0; r < rows; r++) s += data[c * rows + r];
            if (s < bs) begin
                bs = s;
                bi = c;
            end
        end
    endtask

    // runs one search on instance b; gaps randomizes sad_valid while ready, valid stays high otherwise;
    // poke pulses start at that loop cycle while the search is in progress
    task automatic search_b(input string tag, input int data[$], input bit gaps, input int poke);
        int q[$];
        int x0, d0, es, ei;
        bit got_done;
        q = data;
        x0 = xfer_b;
        d0 = ndone_b;
        got_done = 0;
        @(negedge clk) start_b = 1;
        @(negedge clk) start_b = 0;
        for (int c = 0; c < 400 && !got_done; c++) begin
            start_b = (c == poke);
            if (q.size() > 0) begin
                valid_b  = (gaps && ready_b) ? ($urandom_range(0, 2) != 0) : 1'b1;
                sad_in_b = 12'(q[0]);
                if (valid_b && ready_b) void'(q.pop_front());
            end else begin
                valid_b  = 1'b1;
                sad_in_b = 12'hABC;
            end
            @(negedge clk);
            if (done_b) begin
                got_done = 1;
                got_sad  = int'(best_sad_b);
                got_idx  = int'(best_idx_b);
            end
        end
        start_b = 0;
        valid_b = 0;
        chk({tag, "_done_seen"}, int'(got_done), 1);
        ref_best(data, 2, es, ei);
        chk({tag, "_best_sad"}, got_sad, es);
        chk({tag, "_best_idx"}, got_idx, ei);
        repeat (3) @(negedge clk);
        chk({tag, "_xfers"}, xfer_b - x0, data.size());
        chk({tag, "_done_pulses"}, ndone_b - d0, 1);
        chk({tag, "_hold_sad"}, int'(best_sad_b), es);
        chk({tag, "_idle"}, int'(busy_b), 0);
    endtask

    initial begin
        int d[$];
        int xs, ds;
        rst = 1;
        start_a = 0; valid_a = 0; sad_in_a = 0;
        start_b = 0; valid_b = 0; sad_in_b = 0;
        repeat (2) @(negedge clk);
        chk("rst_best_sad", int'(best_sad_a), 16'hFFFF);
        chk("rst_best_idx", int'(best_idx_a), 0);
        chk("rst_ready", int'(ready_a), 0);
        chk("rst_busy", int'(busy_a), 0);
        chk("rst_done", int'(done_a), 0);
        rst = 0;

        // reset in the middle of accumulation, applied between clock edges
        @(negedge clk) start_a = 1;
        @(negedge clk) start_a = 0;
        chk("acc_busy", int'(busy_a), 1);
        chk("acc_ready", int'(ready_a), 1);
        xs = xfer_a;
        ds = ndone_a;
        valid_a = 1;
        sad_in_a = 12'd100;
        repeat (5) @(negedge clk);
        valid_a = 0;
        chk("mid_xfers", xfer_a - xs, 5);
        #2 rst = 1;
        #1;
        chk("arst_ready", int'(ready_a), 0);
        chk("arst_busy", int'(busy_a), 0);
        chk("arst_done", int'(done_a), 0);
        chk("arst_best_sad", int'(best_sad_a), 16'hFFFF);
        chk("arst_best_idx", int'(best_idx_a), 0);
        #1 rst = 0;
        valid_a = 1;
        repeat (20) @(negedge clk);
        valid_a = 0;
        chk("arst_no_done", ndone_a - ds, 0);
        chk("arst_stays_idle", int'(busy_a), 0);
        chk("arst_no_consume", xfer_a - xs, 5);

        // maximum sum, done timing relative to the last transfer
        xs = xfer_a;
        @(negedge clk) start_a = 1;
        @(negedge clk) begin
            start_a = 0;
            valid_a = 1;
            sad_in_a = 12'hFFF;
        end
        repeat (16) @(negedge clk);
        valid_a = 0;
        chk("max_xfers", xfer_a - xs, 16);
        chk("max_done_n", int'(done_a), 0);
        @(negedge clk);
        chk("max_done_n1", int'(done_a), 1);
        chk("max_best_sad", int'(best_sad_a), 16'hFFF0);
        chk("max_best_idx", int'(best_idx_a), 0);
        @(negedge clk);
        chk("max_done_n2", int'(done_a), 0);
        chk("max_idle", int'(busy_a), 0);

        // ties, then the same data with stalls
        d = '{10, 5, 3, 4, 6, 1};
        search_b("tie", d, 0, -1);
        chk("tie_const_sad", got_sad, 7);
        chk("tie_const_idx", got_idx, 1);
        search_b("stall", d, 1, -1);
        chk("stall_const_sad", got_sad, 7);

        // restart: start while busy is ignored, then an all-zero search
        search_b("busy_start", d, 1, 3);
        chk("busy_start_sad", got_sad, 7);
        d = '{0, 0, 0, 0, 0, 0};
        search_b("zero", d, 0, -1);
        chk("zero_const_sad", got_sad, 0);
        chk("zero_const_idx", got_idx, 0);

        // random searches, small value ranges sometimes to force ties
        for (int t = 0; t < 10; t++) begin
            int mx;
            mx = (t % 2 == 0) ? 4095 : 3;
            d = {};
            for (int k = 0; k < 6; k++) d.push_back(int'($urandom_range(0, mx)));
            search_b($sformatf("rnd%0d", t), d, 1'($urandom_range(0, 1)), int'($urandom_range(0, 12)));
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
